// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU slice sequencer.
package serial_alu_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Slice operation encodings, presented on S1/S0.
  localparam logic [1:0] OP_ANDNB = 2'b00;  // A AND NOT B
  localparam logic [1:0] OP_NOTA  = 2'b01;  // NOT A
  localparam logic [1:0] OP_INC   = 2'b10;  // A plus 1
  localparam logic [1:0] OP_ADDC  = 2'b11;  // A plus B plus CarryInit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry presented with bit 0. The increment rides on the carry chain,
  // so it starts with a 1; logic ops never use the carry.
  function automatic logic initial_carry(input logic [1:0] op, input logic carry_init);
    logic c;
    c = 1'b0;
    case (op)
      OP_INC:  c = 1'b1;
      OP_ADDC: c = carry_init;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_shift_reg.sv
// Right-shift register with parallel load, shift enable, serial input at
// the MSB and synchronous clear. Reset and clear have priority over load.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // Register update: clear, then load, then shift right with serial_in at the MSB.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for an external combinational 1-bit ALU slice.
// Operands are fed LSB first, one bit per clock; F is shifted into the
// result from the top and CarryOut is fed back as the next CarryIn.
//
//  state | meaning
//  IDLE  | waiting for Start; slice inputs driven 0
//  RUN   | presenting bit cnt to the slice, capturing F/CarryOut each edge
//  DONE  | one-cycle Done pulse, Result/CarryFinal valid
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryInit,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryFinal,
  output logic             S1,
  output logic             S0,
  output logic             A,
  output logic             B,
  output logic             CarryIn,
  input  logic             F,
  input  logic             CarryOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             run_step;
  logic             last_bit;
  logic [1:0]       op_q;
  logic             carry_q;
  logic             carry_final_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] result_q;

  assign last_bit = (cnt_q == LAST_BIT);

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes; Start only matters in IDLE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    run_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run_step = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latched op, carry chain, bit counter and final carry.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q          <= 2'b00;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      carry_final_q <= 1'b0;
    end else if (accept) begin
      op_q    <= Op;
      carry_q <= initial_carry(Op, CarryInit);
      cnt_q   <= '0;
    end else if (run_step) begin
      carry_q <= CarryOut;
      cnt_q   <= cnt_q + 1'b1;
      if (last_bit) begin
        carry_final_q <= CarryOut;
      end
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_opa_sr (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (1'b0),
    .load      (accept),
    .load_val  (OpA),
    .shift_en  (run_step),
    .serial_in (1'b0),
    .q         (opa_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_opb_sr (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (1'b0),
    .load      (accept),
    .load_val  (OpB),
    .shift_en  (run_step),
    .serial_in (1'b0),
    .q         (opb_q)
  );

  // Result is never parallel-loaded; after WIDTH shifts the first F lands in bit 0.
  serial_shift_reg #(.WIDTH(WIDTH)) u_result_sr (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (1'b0),
    .load      (1'b0),
    .load_val  ('0),
    .shift_en  (run_step),
    .serial_in (F),
    .q         (result_q)
  );

  assign Busy       = (state_q == RUN);
  assign Done       = (state_q == DONE);
  assign Result     = result_q;
  assign CarryFinal = carry_final_q;
  assign S1         = Busy & op_q[1];
  assign S0         = Busy & op_q[0];
  assign A          = Busy & opa_q[0];
  assign B          = Busy & opb_q[0];
  assign CarryIn    = Busy & carry_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench: serial_alu_ctrl paired with a behavioural 1-bit ALU slice.
module tb_serial_alu_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] Op;
  logic [7:0] OpA;
  logic [7:0] OpB;
  logic       CarryInit;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;
  logic       CarryFinal;
  logic       S1, S0, A, B, CarryIn;
  logic       F, CarryOut;

  int vectors    = 0;
  int miscompares = 0;

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OpA        (OpA),
    .OpB        (OpB),
    .CarryInit  (CarryInit),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .CarryFinal (CarryFinal),
    .S1         (S1),
    .S0         (S0),
    .A          (A),
    .B          (B),
    .CarryIn    (CarryIn),
    .F          (F),
    .CarryOut   (CarryOut)
  );

  // The external combinational slice.
  always_comb begin
    F        = 1'b0;
    CarryOut = 1'b0;
    case ({S1, S0})
      2'b00: F = A & ~B;
      2'b01: F = ~A;
      2'b10: begin
        F        = A ^ CarryIn;
        CarryOut = A & CarryIn;
      end
      default: begin
        F        = A ^ B ^ CarryIn;
        CarryOut = (A & B) | (A & CarryIn) | (B & CarryIn);
      end
    endcase
  end

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One request from Start to the cycle after Done. With disturb set, Start
  // stays high with different operands throughout RUN and must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_res, input logic exp_cf,
                        input bit disturb);
    logic prev_cout;
    logic exp_cin;
    prev_cout = 1'b0;
    @(negedge Clock);
    Start = 1'b1; Op = op; OpA = a; OpB = b; CarryInit = cin;
    @(negedge Clock);
    if (disturb) begin
      Op = 2'b00; OpA = 8'h12; OpB = 8'h34; CarryInit = 1'b1;
    end else begin
      Start = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge Clock);
      check("busy_run", Busy, 1);
      check("done_run", Done, 0);
      check("select", {S1, S0}, op);
      check("a_bit", A, a[i]);
      check("b_bit", B, b[i]);
      if (i == 0) exp_cin = (op == 2'b11) ? cin : (op == 2'b10);
      else        exp_cin = prev_cout;
      check("carry_in", CarryIn, exp_cin);
      prev_cout = CarryOut;
    end
    @(negedge Clock);
    check("done_pulse", Done, 1);
    check("busy_done", Busy, 0);
    check("result", Result, exp_res);
    check("carry_final", CarryFinal, exp_cf);
    check("slice_idle", {S1, S0, A, B, CarryIn}, 0);
    Start = 1'b0;
    @(negedge Clock);
    check("done_one_cycle", Done, 0);
    check("busy_after", Busy, 0);
    check("result_held", Result, exp_res);
    check("carry_held", CarryFinal, exp_cf);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; OpA = 8'h00; OpB = 8'h00; CarryInit = 1'b0;
    @(negedge Clock);
    Start = 1'b1;  // reset has priority over Start
    @(negedge Clock);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_result", Result, 0);
    check("reset_cf", CarryFinal, 0);
    check("reset_slice", {S1, S0, A, B, CarryIn}, 0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    check("idle_busy", Busy, 0);

    // 0x5A + 0x3C + 1 = 0x97, no carry out
    run_op(2'b11, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0);
    // 0xFF + 1 wraps to 0x00 with carry
    run_op(2'b10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    // 0xF0 & ~0xCC = 0x30
    run_op(2'b00, 8'hF0, 8'hCC, 1'b1, 8'h30, 1'b0, 1'b0);
    // ~0xA5 = 0x5A
    run_op(2'b01, 8'hA5, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
    // 0xFF + 0x01 = 0x00 carry 1, Start re-asserted during RUN
    run_op(2'b11, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset during the 4th RUN cycle
    @(negedge Clock);
    Start = 1'b1; Op = 2'b11; OpA = 8'h5A; OpB = 8'h3C; CarryInit = 1'b1;
    @(negedge Clock);              // RUN cycle 1
    Start = 1'b0;
    check("abort_busy_pre", Busy, 1);
    @(negedge Clock);              // RUN cycle 2
    @(negedge Clock);              // RUN cycle 3
    @(negedge Clock);              // RUN cycle 4
    check("abort_busy_c4", Busy, 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_result", Result, 0);
    check("abort_cf", CarryFinal, 0);
    check("abort_slice", {S1, S0, A, B, CarryIn}, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      check("abort_no_done", Done, 0);
      check("abort_idle", Busy, 0);
    end
    run_op(2'b11, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Back-to-back with Start held high: second accepted WIDTH+2 edges later
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; OpA = 8'hF0; OpB = 8'hCC; CarryInit = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      check("b2b_busy1", Busy, 1);
      check("b2b_nodone1", Done, 0);
    end
    @(negedge Clock);              // T0+9
    check("b2b_done1", Done, 1);
    check("b2b_result1", Result, 8'h30);
    check("b2b_cf1", CarryFinal, 0);
    Op = 2'b01; OpA = 8'hA5; OpB = 8'h00;
    @(negedge Clock);              // T0+10: IDLE, second Start sampled at its end
    check("b2b_gap_busy", Busy, 0);
    check("b2b_gap_done", Done, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      check("b2b_busy2", Busy, 1);
      check("b2b_sel2", {S1, S0}, 2'b01);
    end
    @(negedge Clock);              // T0+19
    Start = 1'b0;
    check("b2b_done2", Done, 1);
    check("b2b_result2", Result, 8'h5A);
    check("b2b_cf2", CarryFinal, 0);
    @(negedge Clock);
    check("b2b_end_done", Done, 0);
    check("b2b_end_busy", Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
